// File: rtl/layer_cmd_dispatcher_pkg.sv
// Shared definitions for the layer command dispatcher.
// Holds opcode and status encodings, message field offsets, the one-hot
// FSM state encoding and a saturating 32-bit increment helper.
package layer_cmd_dispatcher_pkg;

    // Message layout: [7:0] opcode, [15:8] seq_id, [127:16] reserved,
    // [MSG-1:128] configuration payload.
    localparam int OPCODE_LSB  = 0;
    localparam int SEQ_ID_LSB  = 8;
    localparam int RSVD_LSB    = 16;
    localparam int RSVD_MSB    = 127;
    localparam int PAYLOAD_LSB = 128;

    localparam logic [7:0] OP_CONFIG       = 8'h01;
    localparam logic [7:0] OP_START        = 8'h02;
    localparam logic [7:0] OP_CONFIG_START = 8'h03;
    localparam logic [7:0] OP_STATUS       = 8'h04;

    localparam logic [7:0] STAT_OK             = 8'h00;
    localparam logic [7:0] STAT_UNSUPPORTED    = 8'h01;
    localparam logic [7:0] STAT_TIMEOUT        = 8'h02;
    localparam logic [7:0] STAT_ENGINE_ERROR   = 8'h03;
    localparam logic [7:0] STAT_NOT_CONFIGURED = 8'h04;

    typedef enum logic [3:0] {
        S_IDLE      = 4'b0001,
        S_DECODE    = 4'b0010,
        S_WAIT_DONE = 4'b0100,
        S_RESPOND   = 4'b1000
    } disp_state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/layer_cmd_dispatcher_exec_watchdog.sv
// Execution watchdog: saturating 32-bit cycle counter with timeout compare.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   clr_i        clear counter to 0 (wins over en_i)
//   en_i         increment counter by 1 (saturating)
//   count_o      current count
//   expired_o    high when count_o + 1 equals C_TIMEOUT_CYCLES
module layer_cmd_dispatcher_exec_watchdog
    import layer_cmd_dispatcher_pkg::*;
#(
    parameter logic [31:0] C_TIMEOUT_CYCLES = 32'd1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [31:0] count_o,
    output logic        expired_o
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = sat_inc32(count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    // Compared against TIMEOUT-1 so the current cycle is the last one allowed.
    assign expired_o = (count_q == (C_TIMEOUT_CYCLES - 32'd1));

endmodule

// File: rtl/layer_cmd_dispatcher.sv
// Layer command dispatcher: accepts assembled command messages, decodes
// the opcode, loads/starts the layer engine, supervises it with a
// watchdog, and returns a completion record.
// Handshakes: a message transfers on a cycle where msg_in_valid and
// msg_in_accept are both high; a completion transfers on a cycle where
// cmpl_valid and cmpl_ready are both high. While cmpl_valid is high all
// cmpl_* fields stay stable.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   msg_in_valid/accept/data      command message input
//   eng_cfg_data/eng_cfg_load     configuration to engine (load pulse)
//   eng_start, eng_abort          engine start / abort pulses
//   eng_done, eng_error           engine completion pulse and error flag
//   cmpl_valid/ready/status/seq_id/cycles   completion record
//   busy                          high whenever not idle
//   dbg_state                     current FSM state (one-hot)
module layer_cmd_dispatcher
    import layer_cmd_dispatcher_pkg::*;
#(
    parameter int          C_MSG_WIDTH      = 512,
    parameter int          C_CFG_WIDTH      = 384,
    parameter logic [31:0] C_TIMEOUT_CYCLES = 32'd1000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   msg_in_valid,
    output logic                   msg_in_accept,
    input  logic [C_MSG_WIDTH-1:0] msg_in_data,
    output logic [C_CFG_WIDTH-1:0] eng_cfg_data,
    output logic                   eng_cfg_load,
    output logic                   eng_start,
    output logic                   eng_abort,
    input  logic                   eng_done,
    input  logic                   eng_error,
    output logic                   cmpl_valid,
    input  logic                   cmpl_ready,
    output logic [7:0]             cmpl_status,
    output logic [7:0]             cmpl_seq_id,
    output logic [31:0]            cmpl_cycles,
    output logic                   busy,
    output logic [3:0]             dbg_state
);

    disp_state_e            state_q, state_d;
    logic [7:0]             opcode_q, opcode_d;
    logic [7:0]             seq_q, seq_d;
    logic [C_CFG_WIDTH-1:0] payload_q, payload_d;
    logic [C_CFG_WIDTH-1:0] cfg_data_q, cfg_data_d;
    logic                   cfg_loaded_q, cfg_loaded_d;
    logic [31:0]            last_cycles_q, last_cycles_d;
    logic [31:0]            cycles_q, cycles_d;
    logic [7:0]             status_q, status_d;
    logic                   cfg_load_q, cfg_load_d;
    logic                   start_q, start_d;
    logic                   abort_q, abort_d;

    logic                   wd_clr, wd_en, wd_expired;
    logic [31:0]            wd_count;

    // Reserved header bits carry no meaning here.
    logic                   unused_reserved;
    assign unused_reserved = ^msg_in_data[RSVD_MSB:RSVD_LSB];

    layer_cmd_dispatcher_exec_watchdog #(
        .C_TIMEOUT_CYCLES(C_TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .count_o   (wd_count),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        seq_d         = seq_q;
        payload_d     = payload_q;
        cfg_data_d    = cfg_data_q;
        cfg_loaded_d  = cfg_loaded_q;
        last_cycles_d = last_cycles_q;
        cycles_d      = cycles_q;
        status_d      = status_q;
        cfg_load_d    = 1'b0;
        start_d       = 1'b0;
        abort_d       = 1'b0;
        wd_clr        = 1'b0;
        wd_en         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (msg_in_valid && msg_in_accept) begin
                    opcode_d  = msg_in_data[OPCODE_LSB +: 8];
                    seq_d     = msg_in_data[SEQ_ID_LSB +: 8];
                    payload_d = msg_in_data[PAYLOAD_LSB +: C_CFG_WIDTH];
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                status_d = STAT_OK;
                cycles_d = '0;
                state_d  = S_RESPOND;
                case (opcode_q)
                    OP_CONFIG: begin
                        cfg_data_d   = payload_q;
                        cfg_load_d   = 1'b1;
                        cfg_loaded_d = 1'b1;
                    end
                    OP_START: begin
                        if (cfg_loaded_q) begin
                            start_d = 1'b1;
                            wd_clr  = 1'b1;
                            state_d = S_WAIT_DONE;
                        end else begin
                            status_d = STAT_NOT_CONFIGURED;
                        end
                    end
                    OP_CONFIG_START: begin
                        cfg_data_d   = payload_q;
                        cfg_load_d   = 1'b1;
                        cfg_loaded_d = 1'b1;
                        start_d      = 1'b1;
                        wd_clr       = 1'b1;
                        state_d      = S_WAIT_DONE;
                    end
                    OP_STATUS: begin
                        cycles_d = last_cycles_q;
                    end
                    default: begin
                        status_d = STAT_UNSUPPORTED;
                    end
                endcase
            end
            S_WAIT_DONE: begin
                wd_en = 1'b1;
                // Completion takes priority over a coincident timeout.
                if (eng_done) begin
                    status_d      = eng_error ? STAT_ENGINE_ERROR : STAT_OK;
                    cycles_d      = sat_inc32(wd_count);
                    last_cycles_d = sat_inc32(wd_count);
                    state_d       = S_RESPOND;
                end else if (wd_expired) begin
                    abort_d  = 1'b1;
                    status_d = STAT_TIMEOUT;
                    cycles_d = C_TIMEOUT_CYCLES;
                    state_d  = S_RESPOND;
                end
            end
            S_RESPOND: begin
                if (cmpl_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            opcode_q      <= '0;
            seq_q         <= '0;
            payload_q     <= '0;
            cfg_data_q    <= '0;
            cfg_loaded_q  <= 1'b0;
            last_cycles_q <= '0;
            cycles_q      <= '0;
            status_q      <= '0;
            cfg_load_q    <= 1'b0;
            start_q       <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            seq_q         <= seq_d;
            payload_q     <= payload_d;
            cfg_data_q    <= cfg_data_d;
            cfg_loaded_q  <= cfg_loaded_d;
            last_cycles_q <= last_cycles_d;
            cycles_q      <= cycles_d;
            status_q      <= status_d;
            cfg_load_q    <= cfg_load_d;
            start_q       <= start_d;
            abort_q       <= abort_d;
        end
    end

    assign msg_in_accept = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign cmpl_valid    = (state_q == S_RESPOND);
    assign cmpl_status   = status_q;
    assign cmpl_seq_id   = seq_q;
    assign cmpl_cycles   = cycles_q;
    assign eng_cfg_data  = cfg_data_q;
    assign eng_cfg_load  = cfg_load_q;
    assign eng_start     = start_q;
    assign eng_abort     = abort_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_layer_cmd_dispatcher.sv
module tb_layer_cmd_dispatcher;

  localparam int TO = 16;

  logic         clk;
  logic         rst;
  logic         msg_in_valid;
  logic         msg_in_accept;
  logic [511:0] msg_in_data;
  logic [383:0] eng_cfg_data;
  logic         eng_cfg_load;
  logic         eng_start;
  logic         eng_abort;
  logic         eng_done;
  logic         eng_error;
  logic         cmpl_valid;
  logic         cmpl_ready;
  logic [7:0]   cmpl_status;
  logic [7:0]   cmpl_seq_id;
  logic [31:0]  cmpl_cycles;
  logic         busy;
  logic [3:0]   dbg_state;

  layer_cmd_dispatcher #(
    .C_MSG_WIDTH(512),
    .C_CFG_WIDTH(384),
    .C_TIMEOUT_CYCLES(32'd16)
  ) dut (
    .clk(clk), .rst(rst),
    .msg_in_valid(msg_in_valid), .msg_in_accept(msg_in_accept), .msg_in_data(msg_in_data),
    .eng_cfg_data(eng_cfg_data), .eng_cfg_load(eng_cfg_load),
    .eng_start(eng_start), .eng_abort(eng_abort),
    .eng_done(eng_done), .eng_error(eng_error),
    .cmpl_valid(cmpl_valid), .cmpl_ready(cmpl_ready), .cmpl_status(cmpl_status),
    .cmpl_seq_id(cmpl_seq_id), .cmpl_cycles(cmpl_cycles),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // ---------------- observed transaction record ----------------
  logic [7:0]   r_status, r_seq;
  logic [31:0]  r_cycles;
  logic [383:0] r_load_data;
  int r_valid_rel, r_load_n, r_load_rel, r_start_n, r_start_rel, r_abort_n, r_abort_rel;
  bit r_stable_ok, r_release_ok, r_to;

  // ---------------- reference model ----------------
  bit          m_cfg_loaded;
  logic [31:0] m_last_cycles;
  logic [7:0]  exp_status;
  logic [31:0] exp_cycles;
  bit          exp_load, exp_start, exp_abort;
  int          exp_valid_rel, exp_abort_rel;

  // Cycle positions are counted from the handshake edge: cycle 1 is the
  // decode cycle, cycle 2 carries the first pulses / completion.
  task automatic model_cmd(input logic [7:0] op, input int done_n, input bit err);
    bit wait_path;
    wait_path = 0;
    exp_load = 0; exp_start = 0; exp_abort = 0; exp_abort_rel = -1;
    exp_status = 8'h00; exp_cycles = 32'd0; exp_valid_rel = 2;
    case (op)
      8'h01: begin exp_load = 1; m_cfg_loaded = 1; end
      8'h02: begin
        if (m_cfg_loaded) begin exp_start = 1; wait_path = 1; end
        else exp_status = 8'h04;
      end
      8'h03: begin exp_load = 1; exp_start = 1; m_cfg_loaded = 1; wait_path = 1; end
      8'h04: exp_cycles = m_last_cycles;
      default: exp_status = 8'h01;
    endcase
    if (wait_path) begin
      if (done_n >= 1 && done_n <= TO) begin
        exp_status = err ? 8'h03 : 8'h00;
        exp_cycles = done_n;
        m_last_cycles = done_n;
        exp_valid_rel = 2 + done_n;
      end else begin
        exp_abort = 1;
        exp_abort_rel = 2 + TO;
        exp_status = 8'h02;
        exp_cycles = TO;
        exp_valid_rel = 2 + TO;
      end
    end
  endtask

  // ---------------- driver ----------------
  // done_n: engine raises eng_done in the done_n-th cycle counting the
  // eng_start cycle as 1 (0 = never). ready_wait: cycles cmpl_ready stays
  // low after cmpl_valid first appears.
  task automatic run_cmd(input logic [7:0] op, input logic [7:0] seq, input logic [383:0] pl,
                         input int done_n, input bit err, input int ready_wait);
    int rel, wait_left, done_at;
    bit seen_valid, finished;
    r_status = 'x; r_seq = 'x; r_cycles = 'x; r_load_data = 'x;
    r_valid_rel = -1; r_load_n = 0; r_load_rel = -1; r_start_n = 0; r_start_rel = -1;
    r_abort_n = 0; r_abort_rel = -1; r_stable_ok = 1; r_release_ok = 1; r_to = 0;
    wait_left = 0; done_at = -1; seen_valid = 0; finished = 0;
    @(negedge clk);
    msg_in_data = {pl, 112'd0, seq, op};
    msg_in_valid = 1'b1;
    rel = 0;
    while (msg_in_accept !== 1'b1 && rel < 50) begin
      @(negedge clk);
      rel++;
    end
    if (msg_in_accept !== 1'b1) begin
      r_to = 1;
      msg_in_valid = 1'b0;
      return;
    end
    rel = 0;
    while (!finished && rel < 200) begin
      @(negedge clk);
      rel++;
      msg_in_valid = 1'b0;
      eng_done = 1'b0;
      eng_error = 1'b0;
      if (eng_cfg_load) begin r_load_n++; r_load_rel = rel; r_load_data = eng_cfg_data; end
      if (eng_start) begin
        r_start_n++; r_start_rel = rel;
        if (done_n > 0) done_at = rel + done_n - 1;
      end
      if (eng_abort) begin r_abort_n++; r_abort_rel = rel; end
      if (rel == done_at) begin eng_done = 1'b1; eng_error = err; end
      if (seen_valid && cmpl_ready) begin
        if (cmpl_valid !== 1'b0 || msg_in_accept !== 1'b1 || busy !== 1'b0) r_release_ok = 0;
        cmpl_ready = 1'b0;
        finished = 1;
      end else if (cmpl_valid === 1'b1) begin
        if (!seen_valid) begin
          seen_valid = 1;
          r_valid_rel = rel;
          r_status = cmpl_status; r_seq = cmpl_seq_id; r_cycles = cmpl_cycles;
          wait_left = ready_wait;
        end else if (cmpl_status !== r_status || cmpl_seq_id !== r_seq || cmpl_cycles !== r_cycles) begin
          r_stable_ok = 0;
        end
        if (msg_in_accept !== 1'b0 || busy !== 1'b1) r_stable_ok = 0;
        if (wait_left == 0) cmpl_ready = 1'b1;
        else wait_left--;
      end
    end
    if (!finished) r_to = 1;
    eng_done = 1'b0;
    eng_error = 1'b0;
    cmpl_ready = 1'b0;
  endtask

  function automatic logic [383:0] rand_payload();
    logic [383:0] p;
    for (int i = 0; i < 12; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; msg_in_valid = 1'b0; msg_in_data = '0;
    eng_done = 1'b0; eng_error = 1'b0; cmpl_ready = 1'b0;
    m_cfg_loaded = 0; m_last_cycles = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++; if (msg_in_accept !== 1'b1) begin n_fail++; $display("FAIL reset_accept: got %b exp 1", msg_in_accept); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_checks++; if (cmpl_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmpl_valid: got %b exp 0", cmpl_valid); end
    n_checks++; if ({eng_cfg_load, eng_start, eng_abort} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b exp 000", {eng_cfg_load, eng_start, eng_abort}); end
    n_checks++; if (eng_cfg_data !== '0) begin n_fail++; $display("FAIL reset_cfg_data: got %h exp 0", eng_cfg_data); end
    n_checks++; if ({cmpl_status, cmpl_seq_id, cmpl_cycles} !== 48'd0) begin n_fail++; $display("FAIL reset_cmpl_fields: got %h exp 0", {cmpl_status, cmpl_seq_id, cmpl_cycles}); end
  endtask

  task automatic test_start_unconfigured();
    model_cmd(8'h02, 5, 0);
    run_cmd(8'h02, 8'h22, rand_payload(), 5, 0, 0);
    n_checks++; if (r_to) begin n_fail++; $display("FAIL start_unconf_bound: got timeout exp completion"); end
    n_checks++; if (r_start_n !== 0) begin n_fail++; $display("FAIL start_unconf_no_start: got %0d exp 0", r_start_n); end
    n_checks++; if (r_status !== exp_status) begin n_fail++; $display("FAIL start_unconf_status: got %h exp %h", r_status, exp_status); end
    n_checks++; if (r_seq !== 8'h22) begin n_fail++; $display("FAIL start_unconf_seq: got %h exp 22", r_seq); end
  endtask

  task automatic test_config();
    logic [383:0] pl;
    pl = {48{8'hA5}};
    model_cmd(8'h01, 0, 0);
    run_cmd(8'h01, 8'h11, pl, 0, 0, 0);
    n_checks++; if (r_load_n !== 1 || r_load_rel !== 2) begin n_fail++; $display("FAIL config_load: got n=%0d at %0d exp n=1 at 2", r_load_n, r_load_rel); end
    n_checks++; if (r_load_data !== pl) begin n_fail++; $display("FAIL config_data: got %h exp %h", r_load_data, pl); end
    n_checks++; if (r_start_n !== 0) begin n_fail++; $display("FAIL config_no_start: got %0d exp 0", r_start_n); end
    n_checks++; if (r_status !== exp_status || r_seq !== 8'h11) begin n_fail++; $display("FAIL config_cmpl: got st=%h seq=%h exp st=%h seq=11", r_status, r_seq, exp_status); end
    n_checks++; if (r_valid_rel !== exp_valid_rel) begin n_fail++; $display("FAIL config_latency: got %0d exp %0d", r_valid_rel, exp_valid_rel); end
  endtask

  task automatic test_config_start_status();
    model_cmd(8'h03, 10, 0);
    run_cmd(8'h03, 8'h33, rand_payload(), 10, 0, 0);
    n_checks++; if (r_load_rel !== 2 || r_start_rel !== 2) begin n_fail++; $display("FAIL cs_pulses: got load@%0d start@%0d exp 2,2", r_load_rel, r_start_rel); end
    n_checks++; if (r_status !== exp_status || r_cycles !== exp_cycles) begin n_fail++; $display("FAIL cs_cmpl: got st=%h cyc=%0d exp st=%h cyc=%0d", r_status, r_cycles, exp_status, exp_cycles); end
    n_checks++; if (r_valid_rel !== exp_valid_rel) begin n_fail++; $display("FAIL cs_latency: got %0d exp %0d", r_valid_rel, exp_valid_rel); end
    model_cmd(8'h04, 0, 0);
    run_cmd(8'h04, 8'h44, '0, 0, 0, 0);
    n_checks++; if (r_status !== 8'h00 || r_cycles !== exp_cycles || r_cycles !== 32'd10) begin n_fail++; $display("FAIL status_cycles: got st=%h cyc=%0d exp st=00 cyc=10", r_status, r_cycles); end
  endtask

  task automatic test_timeout();
    model_cmd(8'h02, 0, 0);
    run_cmd(8'h02, 8'h55, '0, 0, 0, 0);
    n_checks++; if (r_abort_n !== 1 || r_abort_rel - r_start_rel !== TO) begin n_fail++; $display("FAIL to_abort: got n=%0d delta=%0d exp n=1 delta=%0d", r_abort_n, r_abort_rel - r_start_rel, TO); end
    n_checks++; if (r_status !== 8'h02 || r_cycles !== 32'd16) begin n_fail++; $display("FAIL to_cmpl: got st=%h cyc=%0d exp st=02 cyc=16", r_status, r_cycles); end
    model_cmd(8'h02, TO, 0);
    run_cmd(8'h02, 8'h56, '0, TO, 0, 0);
    n_checks++; if (r_abort_n !== 0) begin n_fail++; $display("FAIL to_done_wins_abort: got %0d exp 0", r_abort_n); end
    n_checks++; if (r_status !== exp_status || r_cycles !== exp_cycles) begin n_fail++; $display("FAIL to_done_wins_cmpl: got st=%h cyc=%0d exp st=%h cyc=%0d", r_status, r_cycles, exp_status, exp_cycles); end
    model_cmd(8'h02, 15, 1);
    run_cmd(8'h02, 8'h57, '0, 15, 1, 0);
    n_checks++; if (r_status !== exp_status || r_cycles !== exp_cycles) begin n_fail++; $display("FAIL engine_error: got st=%h cyc=%0d exp st=%h cyc=%0d", r_status, r_cycles, exp_status, exp_cycles); end
  endtask

  task automatic test_unsupported_backpressure();
    model_cmd(8'h7F, 0, 0);
    run_cmd(8'h7F, 8'h66, rand_payload(), 0, 0, 5);
    n_checks++; if (!r_stable_ok) begin n_fail++; $display("FAIL bp_stable: fields or accept/busy changed while stalled"); end
    n_checks++; if (!r_release_ok) begin n_fail++; $display("FAIL bp_release: valid/accept/busy wrong after handshake"); end
    n_checks++; if (r_status !== exp_status || r_seq !== 8'h66 || r_cycles !== exp_cycles) begin n_fail++; $display("FAIL bp_cmpl: got st=%h seq=%h cyc=%0d exp st=%h seq=66 cyc=%0d", r_status, r_seq, r_cycles, exp_status, exp_cycles); end
  endtask

  task automatic test_done_ignored_idle();
    @(negedge clk);
    eng_done = 1'b1; eng_error = 1'b1;
    @(negedge clk);
    eng_done = 1'b0; eng_error = 1'b0;
    n_checks++; if (busy !== 1'b0 || cmpl_valid !== 1'b0) begin n_fail++; $display("FAIL idle_done_ignored: got busy=%b valid=%b exp 0,0", busy, cmpl_valid); end
  endtask

  task automatic test_random();
    logic [7:0] op, seq;
    logic [383:0] pl;
    int sel, dn, rw;
    bit er;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: op = 8'h01; 1: op = 8'h02; 2: op = 8'h03; 3: op = 8'h04; 4: op = 8'h02;
        default: begin op = $urandom_range(5, 255); if ($urandom_range(0, 3) == 0) op = 8'h00; end
      endcase
      seq = $urandom; pl = rand_payload();
      dn = $urandom_range(0, 20); er = $urandom_range(0, 1); rw = $urandom_range(0, 3);
      model_cmd(op, dn, er);
      run_cmd(op, seq, pl, dn, er, rw);
      n_checks++;
      if (r_to || r_status !== exp_status || r_seq !== seq || r_cycles !== exp_cycles || r_valid_rel !== exp_valid_rel) begin
        n_fail++;
        $display("FAIL rand_cmpl[%0d] op=%h: got st=%h seq=%h cyc=%0d at %0d to=%b exp st=%h seq=%h cyc=%0d at %0d",
                 i, op, r_status, r_seq, r_cycles, r_valid_rel, r_to, exp_status, seq, exp_cycles, exp_valid_rel);
      end
      n_checks++;
      if (r_load_n !== int'(exp_load) || r_start_n !== int'(exp_start) || r_abort_n !== int'(exp_abort) ||
          (exp_abort && r_abort_rel !== exp_abort_rel) || (exp_load && r_load_data !== pl)) begin
        n_fail++;
        $display("FAIL rand_pulses[%0d] op=%h: got ld=%0d st=%0d ab=%0d@%0d exp ld=%0d st=%0d ab=%0d@%0d",
                 i, op, r_load_n, r_start_n, r_abort_n, r_abort_rel, exp_load, exp_start, exp_abort, exp_abort_rel);
      end
      n_checks++;
      if (!r_stable_ok || !r_release_ok) begin n_fail++; $display("FAIL rand_handshake[%0d]: stable=%b release=%b exp 1,1", i, r_stable_ok, r_release_ok); end
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    msg_in_data = {rand_payload(), 112'd0, 8'h77, 8'h03};
    msg_in_valid = 1'b1;
    @(negedge clk);
    msg_in_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (busy !== 1'b1 || cmpl_valid !== 1'b0) begin n_fail++; $display("FAIL mid_op_busy: got busy=%b valid=%b exp 1,0", busy, cmpl_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_cfg_loaded = 0; m_last_cycles = 0;
    n_checks++; if (busy !== 1'b0 || cmpl_valid !== 1'b0 || msg_in_accept !== 1'b1) begin n_fail++; $display("FAIL mid_rst_state: got busy=%b valid=%b acc=%b exp 0,0,1", busy, cmpl_valid, msg_in_accept); end
    n_checks++; if ({eng_cfg_load, eng_start, eng_abort} !== 3'b000) begin n_fail++; $display("FAIL mid_rst_pulses: got %b exp 000", {eng_cfg_load, eng_start, eng_abort}); end
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || cmpl_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done_ignored: got busy=%b valid=%b exp 0,0", busy, cmpl_valid); end
    model_cmd(8'h02, 3, 0);
    run_cmd(8'h02, 8'h78, '0, 3, 0, 0);
    n_checks++; if (r_status !== exp_status || r_start_n !== 0 || r_status !== 8'h04) begin n_fail++; $display("FAIL mid_rst_start: got st=%h starts=%0d exp st=04 starts=0", r_status, r_start_n); end
    model_cmd(8'h04, 0, 0);
    run_cmd(8'h04, 8'h79, '0, 0, 0, 0);
    n_checks++; if (r_cycles !== exp_cycles) begin n_fail++; $display("FAIL mid_rst_last_cycles: got %0d exp %0d", r_cycles, exp_cycles); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_start_unconfigured();
    test_config();
    test_config_start_status();
    test_timeout();
    test_unsupported_backpressure();
    test_done_ignored_idle();
    test_random();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit: simulation did not complete within 1000000 time units");
    $fatal(1, "time limit");
  end

endmodule
